alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: RR_INIT, default 0, requester favoured first after reset (0 or 1).
REQ-002 SHALL have ports: clock  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have, for each requester i in {0,1}: reqi_valid input 1; reqi_ready output 1; reqi_op input alu_op_e; reqi_a input 8; reqi_b input 8 (request channel).
REQ-004 SHALL have, for each i: rspi_valid output 1; rspi_ready input 1; rspi_result output 8; rspi_flag output alu_flag_e; rspi_err output 1 (response channel).
REQ-005 SHALL have ALU-side ports: alu_enable output 1; alu_op output alu_op_e; alu_register1 output 8; alu_register2 output 8; alu_result input 8; alu_flag input alu_flag_e.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESPOND; single shared ALU; one operation in flight.
REQ-007 IDLE: reqi_ready SHALL be 1 only for the granted requester, combinationally, when it has reqi_valid=1; all other ready outputs 0.
REQ-008 Grant: only one valid -> that one; both valid -> requester named by round-robin pointer; pointer SHALL flip to the other requester on every accepted request.
REQ-009 Handshake edge (valid&ready in IDLE): SHALL register op, a, b, owner id; next state ISSUE.
REQ-010 ISSUE (1 cycle): alu_op/alu_register1/alu_register2 SHALL drive registered op/a/b; alu_enable=0; next CAPTURE.
REQ-011 CAPTURE (1 cycle): operands and op SHALL stay unchanged; alu_enable=1; at the edge alu_result and alu_flag SHALL be latched; next RESPOND.
REQ-012 RESPOND: rsp{owner}_valid=1 with latched result/flag, held stable until rsp{owner}_ready=1; on that edge -> IDLE; other requester's rsp_valid SHALL stay 0.
REQ-013 Latency: rsp_valid SHALL rise exactly 3 cycles after the request handshake edge when rsp_ready is held 1; max throughput one op per 4 cycles.
REQ-014 Outside ISSUE/CAPTURE, alu_enable SHALL be 0 and alu_op/alu_register1/alu_register2 SHALL hold last values (no glitching while idle).
REQ-015 rspi_err SHALL be 0 unless set per REQ-020; valid and held only while rspi_valid=1.
REQ-016 A new request arriving during ISSUE/CAPTURE/RESPOND SHALL wait (ready=0); no request dropped, no request duplicated.

Reset
REQ-017 reset_n=0 SHALL asynchronously force: state IDLE, pointer=RR_INIT, all ready/rsp_valid/rsp_err/alu_enable 0, alu_op/registers and latched result 0, rsp_flag ZERO.
REQ-018 Reset mid-operation SHALL abandon the in-flight op; no response SHALL be produced for it after reset release.
REQ-019 First grant after reset release SHALL occur no earlier than the first rising clock edge with reset_n=1.

Configuration
REQ-020 Macro ALU_ARB_DIV0_TRAP_EN defined: accepted request with op=DIV and b=0 SHALL skip ISSUE/CAPTURE, go IDLE->RESPOND directly, return result 8'hFF, flag NONE, err=1, alu_enable never asserted; latency 1 cycle.
REQ-021 Macro undefined: DIV by zero SHALL be sequenced like any other op, ALU output returned unchanged, err tied 0.

Verification
REQ-022 req0 ADD a=200 b=100, rsp0_ready=1 -> rsp0_valid 3 cycles after handshake, result 44, flag CARRY, err 0.
REQ-023 req0 and req1 valid same cycle (req0 SUB 9-4, req1 AND F0&3C), RR_INIT=0 -> req0 served first (5), then req1 (0x30, flag NONE); next simultaneous pair -> req1 wins.
REQ-024 req1 MUL 3*4 with rsp1_ready=0 for 5 cycles -> rsp1_valid/result 12 held stable 5 cycles, FSM returns IDLE the edge rsp1_ready=1; req0 meanwhile stays ready=0.
REQ-025 DIV 7/2 -> result 3, flag REMAINDER; DIV 0/5 -> result 0, flag ZERO.
REQ-026 reset_n pulled 0 during CAPTURE -> all outputs reset asynchronously, no rsp_valid after release; fresh ADD 1+1 then returns 2.
REQ-027 With ALU_ARB_DIV0_TRAP_EN: DIV 5/0 -> rsp_valid next cycle, result FF, err 1, alu_enable stays 0; without macro: normal 3-cycle path, err 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared 8-bit ALU, one operation in flight.
// Optional feature macro ALU_ARB_DIV0_TRAP_EN: DIV by zero is answered locally without using the ALU.

package alu_arbiter_pkg;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MUL = 3'd5,
    ALU_DIV = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    FLAG_ZERO      = 2'd0,
    FLAG_NONE      = 2'd1,
    FLAG_CARRY     = 2'd2,
    FLAG_REMAINDER = 2'd3
  } alu_flag_e;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  alu_op_e       req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  alu_op_e       req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_result,
  output alu_flag_e     rsp0_flag,
  output logic          rsp0_err,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_result,
  output alu_flag_e     rsp1_flag,
  output logic          rsp1_err,
  output logic          alu_enable,
  output alu_op_e       alu_op,
  output logic [DW-1:0] alu_register1,
  output logic [DW-1:0] alu_register2,
  input  logic [DW-1:0] alu_result,
  input  alu_flag_e     alu_flag
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          owner_q, owner_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  alu_op_e       op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  alu_flag_e     flag_q, flag_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;

  logic [1:0]    ready_c;
  logic          gnt_c;
  alu_op_e       sel_op_c;
  logic [DW-1:0] sel_a_c;
  logic [DW-1:0] sel_b_c;
  logic          trap_c;

  // Requester selection: a lone requester wins, a tie goes to the round-robin pointer.
  always_comb begin
    gnt_c    = (req0_valid && req1_valid) ? rr_q : req1_valid;
    sel_op_c = gnt_c ? req1_op : req0_op;
    sel_a_c  = gnt_c ? req1_a  : req0_a;
    sel_b_c  = gnt_c ? req1_b  : req0_b;
`ifdef ALU_ARB_DIV0_TRAP_EN
    trap_c   = (sel_op_c == ALU_DIV) && (sel_b_c == '0);
`else
    trap_c   = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    flag_d      = flag_q;
    err_d       = err_q;
    en_d        = 1'b0;
    rsp_valid_d = rsp_valid_q;
    ready_c     = '0;
    unique case (state_q)
      IDLE: begin
        // Ready is suppressed while reset is held so no grant precedes the first live edge.
        if (reset_n && (req0_valid || req1_valid)) begin
          ready_c = gnt_c ? 2'b10 : 2'b01;
          rr_d    = ~rr_q;
          owner_d = gnt_c;
          if (trap_c) begin
            res_d       = '1;
            flag_d      = FLAG_NONE;
            err_d       = 1'b1;
            rsp_valid_d = ready_c;
            state_d     = RESPOND;
          end else begin
            op_d    = sel_op_c;
            a_d     = sel_a_c;
            b_d     = sel_b_c;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        en_d    = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        res_d       = alu_result;
        flag_d      = alu_flag;
        err_d       = 1'b0;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESPOND;
      end
      RESPOND: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          rsp_valid_d = '0;
          err_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'(RR_INIT);
      owner_q     <= 1'b0;
      en_q        <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      flag_q      <= FLAG_ZERO;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      en_q        <= en_d;
      err_q       <= err_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      flag_q      <= flag_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req0_ready    = ready_c[0];
  assign req1_ready    = ready_c[1];
  assign rsp0_valid    = rsp_valid_q[0];
  assign rsp1_valid    = rsp_valid_q[1];
  assign rsp0_result   = res_q;
  assign rsp1_result   = res_q;
  assign rsp0_flag     = flag_q;
  assign rsp1_flag     = flag_q;
  assign rsp0_err      = err_q & rsp_valid_q[0];
  assign rsp1_err      = err_q & rsp_valid_q[1];
  assign alu_enable    = en_q;
  assign alu_op        = op_q;
  assign alu_register1 = a_q;
  assign alu_register2 = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, grant/response predictor feeding a scoreboard queue,
// independent response monitor, directed scenarios then random traffic.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned RR_INIT = 0;
`ifdef ALU_ARB_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  alu_op_e req0_op, req1_op, alu_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [7:0] rsp0_result, rsp1_result;
  alu_flag_e rsp0_flag, rsp1_flag, alu_flag;
  logic alu_enable;
  logic [7:0] alu_register1, alu_register2, alu_result;

  alu_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flag(rsp0_flag), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flag(rsp1_flag), .rsp1_err(rsp1_err),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_register1(alu_register1), .alu_register2(alu_register2),
    .alu_result(alu_result), .alu_flag(alu_flag)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural ALU: plain arithmetic, flags ranked carry > zero > remainder > none.
  typedef struct packed { logic [7:0] res; alu_flag_e flag; } alu_out_t;

  function automatic alu_out_t alu_ref(alu_op_e op, logic [7:0] a, logic [7:0] b);
    alu_out_t o;
    int full;
    bit carry;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin full = int'(a) + int'(b); carry = full > 255; end
      ALU_SUB: begin full = int'(a) - int'(b); carry = a < b; end
      ALU_AND: full = int'(a & b);
      ALU_OR:  full = int'(a | b);
      ALU_XOR: full = int'(a ^ b);
      ALU_MUL: begin full = int'(a) * int'(b); carry = full > 255; end
      default: full = (b == 8'd0) ? 255 : int'(a) / int'(b);
    endcase
    o.res = 8'(full);
    if (op == ALU_DIV && b == 8'd0) o.flag = FLAG_NONE;
    else if (carry) o.flag = FLAG_CARRY;
    else if (o.res == 8'd0) o.flag = FLAG_ZERO;
    else if (op == ALU_DIV && (a % b) != 8'd0) o.flag = FLAG_REMAINDER;
    else o.flag = FLAG_NONE;
    return o;
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_ref(alu_op, alu_register1, alu_register2);
  assign alu_result = alu_o.res;
  assign alu_flag   = alu_o.flag;

  typedef struct { int owner; int res; int flag; int err; int due; } exp_t;
  exp_t sb_q[$];

  // Predictor: arbitration model, ALU-port expectations, pushes expected responses.
  int busy = 0, ptr = RR_INIT, en_cyc = -10;
  alu_op_e p_op;
  logic [7:0] p_a, p_b;
  always @(negedge clock) begin
    int g;
    bit e0, e1, trap;
    alu_op_e op;
    logic [7:0] a, b;
    alu_out_t r;
    if (!reset_n) begin
      busy = 0; ptr = RR_INIT; en_cyc = -10;
      sb_q.delete();
    end else begin
      chk("alu_enable", int'(alu_enable), int'(cyc == en_cyc));
      if (cyc == en_cyc || cyc == en_cyc - 1) begin
        chk("alu_op", int'(alu_op), int'(p_op));
        chk("alu_register1", int'(alu_register1), int'(p_a));
        chk("alu_register2", int'(alu_register2), int'(p_b));
      end
      e0 = 1'b0; e1 = 1'b0; g = 0;
      if (busy == 0 && (req0_valid || req1_valid)) begin
        g  = (req0_valid && req1_valid) ? ptr : (req1_valid ? 1 : 0);
        e0 = (g == 0); e1 = (g == 1);
      end
      chk("req0_ready", int'(req0_ready), int'(e0));
      chk("req1_ready", int'(req1_ready), int'(e1));
      if (e0 || e1) begin
        op = g ? req1_op : req0_op;
        a  = g ? req1_a : req0_a;
        b  = g ? req1_b : req0_b;
        ptr  = 1 - ptr;
        busy = 1;
        trap = TRAP && op == ALU_DIV && b == 8'd0;
        if (trap) begin
          sb_q.push_back('{g, 255, int'(FLAG_NONE), 1, cyc + 1});
          en_cyc = -10;
        end else begin
          r = alu_ref(op, a, b);
          sb_q.push_back('{g, int'(r.res), int'(r.flag), 0, cyc + 3});
          en_cyc = cyc + 2;
          p_op = op; p_a = a; p_b = b;
        end
      end else if (busy != 0 && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
        busy = 0;
      end
    end
  end

  // Monitor: pops the scoreboard when a response appears and checks it every cycle it is held.
  exp_t cur;
  bit active = 1'b0;
  always @(negedge clock) begin
    int idx;
    if (!reset_n) begin
      active = 1'b0;
    end else begin
      chk("rsp_exclusive", int'(rsp0_valid && rsp1_valid), 0);
      if (rsp0_valid || rsp1_valid) begin
        idx = rsp1_valid ? 1 : 0;
        if (!active) begin
          if (sb_q.size() == 0) fail("rsp_unexpected", idx, -1);
          else begin
            cur = sb_q.pop_front();
            active = 1'b1;
            chk("rsp_owner", idx, cur.owner);
            chk("rsp_rise_cycle", cyc, cur.due);
          end
        end
        if (active) begin
          chk("rsp_result", int'(idx ? rsp1_result : rsp0_result), cur.res);
          chk("rsp_flag", int'(idx ? rsp1_flag : rsp0_flag), cur.flag);
          chk("rsp_err", int'(idx ? rsp1_err : rsp0_err), cur.err);
          if (idx ? rsp1_ready : rsp0_ready) active = 1'b0;
        end
      end else begin
        chk("rsp_err_idle", int'(rsp0_err || rsp1_err), 0);
        if (active) begin
          fail("rsp_dropped", 0, 1);
          active = 1'b0;
        end
        if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
          fail("rsp_missing", cyc, sb_q[0].due);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input int i, input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    if (i == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic wait_ready(input int i, output int hs);
    hs = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (i == 0 ? req0_ready : req1_ready) begin hs = cyc; break; end
    end
    if (hs < 0) fail("ready_timeout", i, 1);
    @(posedge clock); #1;
    if (i == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int i, input int res, input int flag,
                          input int err, input int hs, input int lat);
    bit seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (i == 0 ? rsp0_valid : rsp1_valid) begin
        seen = 1'b1;
        chk({tag, "_latency"}, cyc - hs, lat);
        chk({tag, "_result"}, int'(i == 0 ? rsp0_result : rsp1_result), res);
        chk({tag, "_flag"}, int'(i == 0 ? rsp0_flag : rsp1_flag), flag);
        chk({tag, "_err"}, int'(i == 0 ? rsp0_err : rsp1_err), err);
        break;
      end
    end
    if (!seen) fail({tag, "_rsp_timeout"}, i, 1);
    @(posedge clock); #1;
  endtask

  task automatic do_op(input string tag, input int i, input alu_op_e op, input logic [7:0] a,
                       input logic [7:0] b, input int res, input int flag, input int err, input int lat);
    int hs;
    drive(i, op, a, b);
    wait_ready(i, hs);
    wait_rsp(tag, i, res, flag, err, hs, lat);
  endtask

  task automatic rand_req(input int i);
    alu_op_e op;
    logic [7:0] a, b;
    op = alu_op_e'(3'($urandom_range(0, 6)));
    a  = 8'($urandom);
    b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
    drive(i, op, a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int hs0, hs1;
    bit t0, t1;
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_MUL; req0_a = 8'd9; req0_b = 8'd9;
    req1_valid = 1'b0; req1_op = ALU_ADD; req1_a = 8'd0; req1_b = 8'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset values, with a request pending that must not be granted yet.
    @(posedge clock); #1;
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_alu_enable", int'(alu_enable), 0);
    chk("rst_rsp_valid", int'({rsp1_valid, rsp0_valid}), 0);
    chk("rst_alu_op", int'(alu_op), int'(ALU_ADD));
    chk("rst_alu_regs", int'({alu_register1, alu_register2}), 0);
    chk("rst_rsp_flag", int'(rsp0_flag), int'(FLAG_ZERO));
    chk("rst_rsp_result", int'(rsp0_result), 0);
    req0_valid = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Simultaneous pair: req0 first, then req1 beats a re-presented req0.
    drive(0, ALU_SUB, 8'd9, 8'd4);
    drive(1, ALU_AND, 8'hF0, 8'h3C);
    @(negedge clock);
    chk("rr_first_req0", int'(req0_ready), 1);
    chk("rr_first_req1", int'(req1_ready), 0);
    hs0 = cyc;
    @(posedge clock); #1; req0_valid = 1'b0;
    wait_rsp("sub", 0, 5, int'(FLAG_NONE), 0, hs0, 3);
    drive(0, ALU_ADD, 8'd1, 8'd2);
    @(negedge clock);
    chk("rr_second_req1", int'(req1_ready), 1);
    chk("rr_second_req0", int'(req0_ready), 0);
    hs1 = cyc;
    @(posedge clock); #1; req1_valid = 1'b0;
    wait_rsp("and", 1, 'h30, int'(FLAG_NONE), 0, hs1, 3);
    wait_ready(0, hs0);
    wait_rsp("add12", 0, 3, int'(FLAG_NONE), 0, hs0, 3);

    do_op("add_carry", 0, ALU_ADD, 8'd200, 8'd100, 44, int'(FLAG_CARRY), 0, 3);
    do_op("div_rem", 1, ALU_DIV, 8'd7, 8'd2, 3, int'(FLAG_REMAINDER), 0, 3);
    do_op("div_zero_num", 0, ALU_DIV, 8'd0, 8'd5, 0, int'(FLAG_ZERO), 0, 3);
    do_op("div_by_zero", 1, ALU_DIV, 8'd5, 8'd0, 255, int'(FLAG_NONE), int'(TRAP), TRAP ? 1 : 3);

    // Backpressure: response held while a second requester waits.
    rsp1_ready = 1'b0;
    drive(1, ALU_MUL, 8'd3, 8'd4);
    wait_ready(1, hs1);
    drive(0, ALU_ADD, 8'd5, 8'd6);
    for (int k = 0; k < 30 && !rsp1_valid; k++) @(negedge clock);
    chk("bp_latency", cyc - hs1, 3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp1_valid", int'(rsp1_valid), 1);
      chk("bp_rsp1_result", int'(rsp1_result), 12);
      chk("bp_req0_blocked", int'(req0_ready), 0);
      if (k < 4) @(negedge clock);
    end
    @(posedge clock); #1; rsp1_ready = 1'b1;
    @(negedge clock);
    chk("bp_last_hold", int'(rsp1_valid), 1);
    chk("bp_req0_still_blocked", int'(req0_ready), 0);
    @(negedge clock);
    chk("bp_rsp1_cleared", int'(rsp1_valid), 0);
    chk("bp_req0_granted", int'(req0_ready), 1);
    hs0 = cyc;
    @(posedge clock); #1; req0_valid = 1'b0;
    wait_rsp("bp_add", 0, 11, int'(FLAG_NONE), 0, hs0, 3);

    // Reset during CAPTURE abandons the operation.
    drive(0, ALU_ADD, 8'd7, 8'd8);
    wait_ready(0, hs0);
    for (int k = 0; k < 10 && !alu_enable; k++) @(negedge clock);
    chk("rst_mid_in_capture", int'(alu_enable), 1);
    #2 reset_n = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk("rst_mid_alu_enable", int'(alu_enable), 0);
    chk("rst_mid_regs", int'({alu_register1, alu_register2}), 0);
    chk("rst_mid_req1_ready", int'(req1_ready), 0);
    chk("rst_mid_flag", int'(rsp0_flag), int'(FLAG_ZERO));
    req1_valid = 1'b0;
    @(posedge clock); @(posedge clock); #3;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("rst_mid_no_rsp", int'({rsp1_valid, rsp0_valid}), 0);
    end
    @(posedge clock); #1;
    do_op("post_rst_add", 0, ALU_ADD, 8'd1, 8'd1, 2, int'(FLAG_NONE), 0, 3);

    // Random traffic with random response backpressure.
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      t0 = req0_valid && req0_ready;
      t1 = req1_valid && req1_ready;
      @(posedge clock); #1;
      if (t0) req0_valid = 1'b0;
      if (t1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0) rand_req(0);
      if (!req1_valid && $urandom_range(0, 2) == 0) rand_req(1);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      t0 = req0_valid && req0_ready;
      t1 = req1_valid && req1_ready;
      @(posedge clock); #1;
      if (t0) req0_valid = 1'b0;
      if (t1) req1_valid = 1'b0;
    end
    @(negedge clock);
    chk("drain_scoreboard", sb_q.size(), 0);
    chk("drain_pending_requests", int'({req1_valid, req0_valid}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
